// File: rtl/anc_pkg.sv
// Shared Q1.15 constants, FSM state type and saturation helper for the adaptive noise canceller.
// Everything here is combinational; there is no latency and no flow control.
package anc_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC   = 15;

  localparam logic signed [DATA_W-1:0] Q_MAX          = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN          = 16'sh8000;
  localparam logic signed [DATA_W-1:0] W_INIT_DEFAULT = 16'sh2000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } lms_state_e;

  // In range exactly when the three top bits agree; otherwise clamp by sign.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W+1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v[DATA_W+1:DATA_W-1] == 3'b000 || v[DATA_W+1:DATA_W-1] == 3'b111) begin
      r = v[DATA_W-1:0];
    end else if (v[DATA_W+1]) begin
      r = Q_MIN;
    end else begin
      r = Q_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/anc_sat_mac.sv
// Saturating Q1.15 multiply-accumulate: y = sat(w + floor(a*b / 2^15)).
// Purely combinational, zero latency, no backpressure.
module anc_sat_mac
  import anc_pkg::*;
(
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W:0]     delta;
  logic signed [DATA_W+1:0]   sum;
  logic                       unused_frac;

  // Both operands sign-extended to full width, so the low 32 bits are the signed product.
  assign prod        = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
  assign delta       = prod[2*DATA_W-1:FRAC];
  assign unused_frac = ^prod[FRAC-1:0];
  assign sum         = $signed({{2{w_i[DATA_W-1]}}, w_i}) + $signed({delta[DATA_W], delta});
  assign y_o         = sat16(sum);

endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient engine: per error sample, serially updates w[i] += (e>>>MU_SHIFT)*x[i], one tap per cycle.
// Writes appear 1..TAPS cycles after accept, done at TAPS+1; err_valid while busy is dropped and flagged.
module lms_weight_update
  import anc_pkg::*;
#(
  parameter int                       TAPS     = 4,
  parameter int                       MU_SHIFT = 4,
  parameter logic signed [DATA_W-1:0] W_INIT   = W_INIT_DEFAULT,
  localparam int                      ADDR_W   = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] err_in,
  input  logic                     err_valid,
  output logic                     coeff_wr_en,
  output logic [ADDR_W-1:0]        coeff_wr_addr,
  output logic signed [DATA_W-1:0] coeff_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_drop
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  lms_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic signed [DATA_W-1:0] mu_e_q;
  logic signed [DATA_W-1:0] x_q  [TAPS];
  logic signed [DATA_W-1:0] xs_q [TAPS];
  logic signed [DATA_W-1:0] w_q  [TAPS];

  logic                     wr_en_q, busy_q, done_q, drop_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic signed [DATA_W-1:0] wr_data_q;

  logic                     accept, wr_go;
  logic [ADDR_W-1:0]        tap_sel;
  logic signed [DATA_W-1:0] mu_e_in, mac_a, mac_b, mac_y;

  assign mu_e_in = err_in >>> MU_SHIFT;
  assign accept  = (state_q == ST_IDLE) && err_valid;

  // Tap 0 is computed at the accept edge straight from err_in and the live delay line,
  // so each registered write lands one cycle ahead of the next tap's computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tap_sel = '0;
    mac_a   = mu_e_in;
    mac_b   = x_q[0];
    wr_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (err_valid) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
          wr_go   = 1'b1;
        end
      end
      ST_UPDATE: begin
        mac_a = mu_e_q;
        if (idx_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          tap_sel = idx_d;
          wr_go   = 1'b1;
        end
        mac_b = xs_q[tap_sel];
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  anc_sat_mac u_mac (
    .w_i (w_q[tap_sel]),
    .a_i (mac_a),
    .b_i (mac_b),
    .y_o (mac_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mu_e_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]  <= '0;
        xs_q[i] <= '0;
        w_q[i]  <= W_INIT;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (sample_valid) begin
        x_q[0] <= sample_in;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
      if (accept) begin
        mu_e_q <= mu_e_in;
        xs_q   <= x_q;
      end
      if (wr_go) w_q[tap_sel] <= mac_y;
      wr_en_q   <= wr_go;
      wr_addr_q <= wr_go ? tap_sel : '0;
      wr_data_q <= wr_go ? mac_y : '0;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      drop_q    <= err_valid && (state_q != ST_IDLE);
    end
  end

  assign coeff_wr_en   = wr_en_q;
  assign coeff_wr_addr = wr_addr_q;
  assign coeff_wr_data = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_drop      = drop_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update (TAPS=4, MU_SHIFT=4) with hand-computed expected weights.
module tb_lms_weight_update;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] err_in;
  logic        err_valid;
  logic        coeff_wr_en;
  logic [1:0]  coeff_wr_addr;
  logic [15:0] coeff_wr_data;
  logic        busy;
  logic        done;
  logic        err_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lms_weight_update #(
    .TAPS     (4),
    .MU_SHIFT (4),
    .W_INIT   (16'sh2000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .err_in        (err_in),
    .err_valid     (err_valid),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .busy          (busy),
    .done          (done),
    .err_drop      (err_drop)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
  endtask

  task automatic hold_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
  endtask

  // Full update: four writes in cycles 1..4, done in cycle 5, idle in cycle 6.
  task automatic do_update(input string tag, input logic [15:0] err, input logic [3:0][15:0] exp,
                           input logic sv, input logic [15:0] sdat);
    err_in       = err;
    err_valid    = 1'b1;
    sample_in    = sdat;
    sample_valid = sv;
    tick;
    err_valid    = 1'b0;
    sample_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_we%0d", tag, k), 16'(coeff_wr_en), 16'h1);
      chk($sformatf("%s_addr%0d", tag, k), 16'(coeff_wr_addr), 16'(k));
      chk($sformatf("%s_data%0d", tag, k), coeff_wr_data, exp[k]);
      chk($sformatf("%s_busy%0d", tag, k), 16'(busy), 16'h1);
      tick;
    end
    chk({tag, "_done"}, 16'(done), 16'h1);
    chk({tag, "_we_done"}, 16'(coeff_wr_en), 16'h0);
    tick;
    chk({tag, "_done_end"}, 16'(done), 16'h0);
    chk({tag, "_busy_end"}, 16'(busy), 16'h0);
  endtask

  initial begin
    int e;
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    err_in       = '0;
    err_valid    = 1'b0;

    // 1: reset state
    repeat (3) tick;
    chk("rst_we", 16'(coeff_wr_en), 16'h0);
    chk("rst_addr", 16'(coeff_wr_addr), 16'h0);
    chk("rst_data", coeff_wr_data, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_drop", 16'(err_drop), 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_w%0d", i), $unsigned(dut.w_q[i]), 16'h2000);
      chk($sformatf("rst_x%0d", i), $unsigned(dut.x_q[i]), 16'h0000);
    end
    rst = 1'b0;
    tick;

    // 2: x=0x4000 everywhere, e=0x1000 -> mu_e=0x100, delta=0x80
    repeat (4) push(16'h4000);
    do_update("t2", 16'h1000, {4{16'h2080}}, 1'b0, 16'h0);

    // 4: late err_valid is dropped; sample shifted mid-update does not affect writes
    err_in    = 16'h1000;
    err_valid = 1'b1;
    tick;
    err_valid = 1'b0;
    chk("t4_data0", coeff_wr_data, 16'h2100);
    tick;
    chk("t4_addr1", 16'(coeff_wr_addr), 16'h1);
    chk("t4_drop_c2", 16'(err_drop), 16'h0);
    err_valid    = 1'b1;
    err_in       = 16'h7FFF;
    sample_in    = 16'h7FFF;
    sample_valid = 1'b1;
    tick;
    err_valid    = 1'b0;
    sample_valid = 1'b0;
    chk("t4_drop_c3", 16'(err_drop), 16'h1);
    chk("t4_addr2", 16'(coeff_wr_addr), 16'h2);
    chk("t4_data2", coeff_wr_data, 16'h2100);
    tick;
    chk("t4_drop_c4", 16'(err_drop), 16'h0);
    chk("t4_addr3", 16'(coeff_wr_addr), 16'h3);
    chk("t4_data3", coeff_wr_data, 16'h2100);
    tick;
    chk("t4_we_c5", 16'(coeff_wr_en), 16'h0);
    chk("t4_done_c5", 16'(done), 16'h1);
    tick;
    chk("t4_we_c6", 16'(coeff_wr_en), 16'h0);
    chk("t4_busy_c6", 16'(busy), 16'h0);
    chk("t4_x0", $unsigned(dut.x_q[0]), 16'h7FFF);
    chk("t4_x1", $unsigned(dut.x_q[1]), 16'h4000);

    // 6: reset in cycle 2 of an update aborts it
    err_in    = 16'h1000;
    err_valid = 1'b1;
    tick;
    err_valid = 1'b0;
    chk("t6_we_c1", 16'(coeff_wr_en), 16'h1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_we_c3", 16'(coeff_wr_en), 16'h0);
    chk("t6_busy_c3", 16'(busy), 16'h0);
    for (int c = 4; c < 8; c++) begin
      tick;
      chk($sformatf("t6_we_c%0d", c), 16'(coeff_wr_en), 16'h0);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t6_w%0d", i), $unsigned(dut.w_q[i]), 16'h2000);
    repeat (4) push(16'h4000);
    do_update("t6", 16'h1000, {4{16'h2080}}, 1'b0, 16'h0);

    // 5: simultaneous err/sample uses pre-shift x = {0x4000,0x2000,0x1000,0x0800}
    push(16'h0800);
    push(16'h1000);
    push(16'h2000);
    push(16'h4000);
    do_update("t5", 16'h1000, {16'h2090, 16'h20A0, 16'h20C0, 16'h2100}, 1'b1, 16'h7FFF);
    chk("t5_x0", $unsigned(dut.x_q[0]), 16'h7FFF);
    chk("t5_x1", $unsigned(dut.x_q[1]), 16'h4000);

    // 3: floor(0x7FF * 0x7FFF / 2^15) = 0x7FE per update; clamps on the 13th
    hold_reset;
    repeat (4) push(16'h7FFF);
    for (int n = 1; n <= 14; n++) begin
      e = 16'h2000 + n * 16'h07FE;
      if (e > 16'h7FFF) e = 16'h7FFF;
      do_update($sformatf("t3_u%0d", n), 16'h7FFF, {4{16'(e)}}, 1'b0, 16'h0);
    end
    chk("t3_w0_sat", $unsigned(dut.w_q[0]), 16'h7FFF);
    do_update("t3_neg", 16'h8000, {4{16'h77FF}}, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
